// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Two-source register-file writeback arbiter (pipeline / MDU)
//                with WAW tracking of outstanding MDU destinations and an
//                MDU anti-starvation wait counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    output logic        pipe_ready,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_wa,
    input  logic [31:0] mdu_wd,
    output logic        mdu_ready,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_wa,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] pend_mask
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    logic        r_rf_we;
    logic [4:0]  r_rf_wa;
    logic [31:0] r_rf_wd;
    logic [31:0] r_pend_mask;
    logic [3:0]  r_wait_cnt;

    logic        w_pipe_blocked;
    logic        w_mdu_starved;
    logic        w_pipe_xfer;
    logic        w_mdu_xfer;
    logic [31:0] w_pend_next;

    assign w_pipe_blocked = r_pend_mask[pipe_wa];
    assign w_mdu_starved  = mdu_valid && (r_wait_cnt == c_max_wait);

    // Starved MDU beats the pipe; a WAW-blocked pipe never wins.
    always_comb begin
        pipe_ready = 1'b0;
        mdu_ready  = 1'b0;
        if (rst_n) begin
            if (w_mdu_starved) begin
                mdu_ready = 1'b1;
            end else if (pipe_valid && !w_pipe_blocked) begin
                pipe_ready = 1'b1;
            end else if (mdu_valid) begin
                mdu_ready = 1'b1;
            end
        end
    end

    assign w_pipe_xfer = pipe_valid && pipe_ready;
    assign w_mdu_xfer  = mdu_valid && mdu_ready;

    // Clear on MDU retirement first so a same-edge issue to that index wins.
    always_comb begin
        w_pend_next = r_pend_mask;
        if (w_mdu_xfer) begin
            w_pend_next[mdu_wa] = 1'b0;
        end
        if (mdu_issue && (mdu_issue_wa != 5'd0)) begin
            w_pend_next[mdu_issue_wa] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_we     <= 1'b0;
            r_rf_wa     <= 5'd0;
            r_rf_wd     <= 32'd0;
            r_pend_mask <= 32'd0;
            r_wait_cnt  <= 4'd0;
        end else begin
            r_pend_mask <= w_pend_next;

            if (mdu_valid && !mdu_ready) begin
                r_wait_cnt <= (r_wait_cnt == c_max_wait) ? r_wait_cnt : r_wait_cnt + 4'd1;
            end else begin
                r_wait_cnt <= 4'd0;
            end

            if (w_pipe_xfer) begin
                r_rf_we <= (pipe_wa != 5'd0);
                r_rf_wa <= pipe_wa;
                r_rf_wd <= pipe_wd;
            end else if (w_mdu_xfer) begin
                r_rf_we <= (mdu_wa != 5'd0);
                r_rf_wa <= mdu_wa;
                r_rf_wd <= mdu_wd;
            end else begin
                r_rf_we <= 1'b0;
            end
        end
    end

    assign rf_we     = r_rf_we;
    assign rf_wa     = r_rf_wa;
    assign rf_wd     = r_rf_wd;
    assign pend_mask = r_pend_mask;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Self-checking directed-vector bench for rf_wb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    typedef struct {
        logic        rst_n;
        logic        pv;
        logic [4:0]  pwa;
        logic [31:0] pwd;
        logic        mv;
        logic [4:0]  mwa;
        logic [31:0] mwd;
        logic        iss;
        logic [4:0]  iwa;
        logic        epr;
        logic        emr;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [31:0] epm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        pipe_ready;
    logic        mdu_valid;
    logic [4:0]  mdu_wa;
    logic [31:0] mdu_wd;
    logic        mdu_ready;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_wa;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] pend_mask;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    rf_wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_valid   (pipe_valid),
        .pipe_wa      (pipe_wa),
        .pipe_wd      (pipe_wd),
        .pipe_ready   (pipe_ready),
        .mdu_valid    (mdu_valid),
        .mdu_wa       (mdu_wa),
        .mdu_wd       (mdu_wd),
        .mdu_ready    (mdu_ready),
        .mdu_issue    (mdu_issue),
        .mdu_issue_wa (mdu_issue_wa),
        .rf_we        (rf_we),
        .rf_wa        (rf_wa),
        .rf_wd        (rf_wd),
        .pend_mask    (pend_mask)
    );

    function automatic vec_t mk(
        input logic rs, input logic pv, input logic [4:0] pwa, input logic [31:0] pwd,
        input logic mv, input logic [4:0] mwa, input logic [31:0] mwd,
        input logic iss, input logic [4:0] iwa,
        input logic epr, input logic emr, input logic ewe, input logic [4:0] ewa,
        input logic [31:0] ewd, input logic [31:0] epm);
        vec_t v;
        v.rst_n = rs; v.pv = pv; v.pwa = pwa; v.pwd = pwd;
        v.mv = mv; v.mwa = mwa; v.mwd = mwd; v.iss = iss; v.iwa = iwa;
        v.epr = epr; v.emr = emr; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.epm = epm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the readies mid-cycle, then the
    // registered outputs just after the edge.
    task automatic apply(input vec_t v, input string tag);
        rst_n        = v.rst_n;
        pipe_valid   = v.pv;
        pipe_wa      = v.pwa;
        pipe_wd      = v.pwd;
        mdu_valid    = v.mv;
        mdu_wa       = v.mwa;
        mdu_wd       = v.mwd;
        mdu_issue    = v.iss;
        mdu_issue_wa = v.iwa;
        #1;
        chk({tag, " pipe_ready"}, 32'(pipe_ready), 32'(v.epr));
        chk({tag, " mdu_ready"},  32'(mdu_ready),  32'(v.emr));
        @(posedge clk);
        #1;
        chk({tag, " rf_we"},     32'(rf_we), 32'(v.ewe));
        chk({tag, " rf_wa"},     32'(rf_wa), 32'(v.ewa));
        chk({tag, " rf_wd"},     rf_wd,      v.ewd);
        chk({tag, " pend_mask"}, pend_mask,  v.epm);
    endtask

    initial begin
        //               rs pv pwa  pwd          mv mwa  mwd          is iwa  epr emr ewe ewa  ewd          epm
        vecs.push_back(mk(0, 1, 5'd5, 32'h0000_1234, 1, 5'd7, 32'h0000_7777, 1, 5'd4, 0, 0, 0, 5'd0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 1, 5'd5, 32'h0000_1234, 0, 5'd0, 32'h0,         0, 5'd0, 1, 0, 1, 5'd5, 32'h0000_1234, 32'h0));
        vecs.push_back(mk(1, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 0, 0, 0, 5'd5, 32'h0000_1234, 32'h0));
        vecs.push_back(mk(1, 1, 5'd0, 32'hdead_beef, 0, 5'd0, 32'h0,         0, 5'd0, 1, 0, 0, 5'd0, 32'hdead_beef, 32'h0));
        vecs.push_back(mk(1, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd0, 0, 0, 0, 5'd0, 32'hdead_beef, 32'h0));
        vecs.push_back(mk(1, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd9, 0, 0, 0, 5'd0, 32'hdead_beef, 32'h200));
        vecs.push_back(mk(1, 1, 5'd9, 32'h0000_0099, 0, 5'd0, 32'h0,         0, 5'd0, 0, 0, 0, 5'd0, 32'hdead_beef, 32'h200));
        vecs.push_back(mk(1, 1, 5'd9, 32'h0000_0099, 1, 5'd9, 32'h0000_aaaa, 0, 5'd0, 0, 1, 1, 5'd9, 32'h0000_aaaa, 32'h0));
        vecs.push_back(mk(1, 1, 5'd9, 32'h0000_0099, 0, 5'd0, 32'h0,         0, 5'd0, 1, 0, 1, 5'd9, 32'h0000_0099, 32'h0));
        vecs.push_back(mk(1, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd3, 0, 0, 0, 5'd9, 32'h0000_0099, 32'h8));
        vecs.push_back(mk(1, 0, 5'd0, 32'h0,         1, 5'd3, 32'h0000_0033, 1, 5'd3, 0, 1, 1, 5'd3, 32'h0000_0033, 32'h8));
        vecs.push_back(mk(1, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd3, 0, 0, 0, 5'd3, 32'h0000_0033, 32'h8));
        vecs.push_back(mk(1, 0, 5'd0, 32'h0,         1, 5'd3, 32'h0000_3333, 0, 5'd0, 0, 1, 1, 5'd3, 32'h0000_3333, 32'h0));
        vecs.push_back(mk(1, 1, 5'd5, 32'h0000_0001, 1, 5'd7, 32'h0000_0002, 0, 5'd0, 1, 0, 1, 5'd5, 32'h0000_0001, 32'h0));
        // Mid-operation reset: pend 0x600, wait_cnt 3, then reset for one cycle.
        vecs.push_back(mk(0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 0, 0, 0, 5'd0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd9, 0, 0, 0, 5'd0, 32'h0,         32'h200));
        vecs.push_back(mk(1, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 5'd10,0, 0, 0, 5'd0, 32'h0,         32'h600));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 1, 5'd5, 32'h0000_0011, 1, 5'd7, 32'h0000_0077, 0, 5'd0, 1, 0, 1, 5'd5, 32'h0000_0011, 32'h600));
        vecs.push_back(mk(0, 1, 5'd5, 32'h0000_0011, 1, 5'd7, 32'h0000_0077, 1, 5'd12,0, 0, 0, 5'd0, 32'h0,         32'h0));
        vecs.push_back(mk(1, 1, 5'd9, 32'h0000_0099, 0, 5'd0, 32'h0,         0, 5'd0, 1, 0, 1, 5'd9, 32'h0000_0099, 32'h0));
        // Wait count must restart from zero after reset: MDU wins on the 5th cycle.
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, 1, 5'd5, 32'h0000_0011, 1, 5'd7, 32'h0000_0077, 0, 5'd0, 1, 0, 1, 5'd5, 32'h0000_0011, 32'h0));
        vecs.push_back(mk(1, 1, 5'd5, 32'h0000_0011, 1, 5'd7, 32'h0000_0077, 0, 5'd0, 0, 1, 1, 5'd7, 32'h0000_0077, 32'h0));

        rst_n = 1'b0; pipe_valid = 1'b0; pipe_wa = '0; pipe_wd = '0;
        mdu_valid = 1'b0; mdu_wa = '0; mdu_wd = '0; mdu_issue = 1'b0; mdu_issue_wa = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Continuous contention: pipe wins four, MDU wins the fifth, repeating.
        apply(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 32'h0), "arb_rst");
        for (int i = 0; i < 15; i++) begin
            logic m;
            m = ((i % 5) == 4);
            apply(mk(1, 1, 5'd5, 32'h0000_5555, 1, 5'd7, 32'h0000_7777, 0, 5'd0,
                     !m, m, 1, m ? 5'd7 : 5'd5, m ? 32'h0000_7777 : 32'h0000_5555, 32'h0),
                  $sformatf("arb%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive stalled cycles after which the MDU requester is forced to win (legal range 1..15).
REQ-002 The block SHALL run on one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-005 The block SHALL have port pipe_valid  in  1  pipeline writeback request.
REQ-006 The block SHALL have port pipe_wa  in  5  pipeline destination register.
REQ-007 The block SHALL have port pipe_wd  in  32  pipeline write data.
REQ-008 The block SHALL have port pipe_ready  out  1  pipeline request accepted this cycle.
REQ-009 The block SHALL have port mdu_valid  in  1  multi-cycle unit writeback request.
REQ-010 The block SHALL have port mdu_wa  in  5  MDU destination register.
REQ-011 The block SHALL have port mdu_wd  in  32  MDU write data.
REQ-012 The block SHALL have port mdu_ready  out  1  MDU request accepted this cycle.
REQ-013 The block SHALL have port mdu_issue  in  1  pulse: an MDU op was issued.
REQ-014 The block SHALL have port mdu_issue_wa  in  5  destination of the issued MDU op.
REQ-015 The block SHALL have port rf_we  out  1  register-file write enable (registered).
REQ-016 The block SHALL have port rf_wa  out  5  register-file write address (registered).
REQ-017 The block SHALL have port rf_wd  out  32  register-file write data (registered).
REQ-018 The block SHALL have port pend_mask  out  32  registers with an outstanding MDU write (registered).

Function
REQ-019 The block SHALL accept a request on a source only when that source's valid and ready are both high; requesters hold valid, wa and wd stable until accepted.
REQ-020 The block SHALL assert at most one of pipe_ready and mdu_ready in any cycle; both readies are combinational from the current valids, pipe_wa, pend_mask and wait_cnt.
REQ-021 Arbitration SHALL be: if mdu_valid and wait_cnt==MAX_WAIT, grant MDU; else if pipe_valid and pend_mask[pipe_wa]==0, grant pipe; else if mdu_valid, grant MDU; else no grant.
REQ-022 When pend_mask[pipe_wa]==1 (WAW against an older MDU write), the block SHALL hold pipe_ready low regardless of mdu_valid.
REQ-023 Internal wait_cnt (4 bits) SHALL increment, saturating at MAX_WAIT, each cycle mdu_valid is high and mdu_ready is low; it SHALL clear on any cycle mdu_valid is low or mdu_ready is high.
REQ-024 On an accepted transfer, the block SHALL register the next cycle rf_wa=granted wa, rf_wd=granted wd, rf_we=1 unless the granted wa==0, in which case rf_we=0 (the request is still accepted).
REQ-025 With no transfer, rf_we SHALL be 0 the next cycle; rf_wa/rf_wd hold their last values.
REQ-026 Write latency SHALL be exactly 1 cycle from the accepting edge to rf_we high.
REQ-027 mdu_issue with mdu_issue_wa!=0 SHALL set pend_mask[mdu_issue_wa] at the next edge; issue to register 0 SHALL be ignored; pend_mask[0] SHALL always be 0.
REQ-028 An accepted MDU transfer SHALL clear pend_mask[mdu_wa] at the same edge.
REQ-029 On a simultaneous set and clear of the same index, set SHALL win (bit stays 1).
REQ-030 Issue to an already-pending register SHALL leave the bit at 1 (no counting).

Reset
REQ-031 While rst_n is low at a rising edge, the block SHALL clear rf_we, rf_wa, rf_wd, pend_mask and wait_cnt to 0.
REQ-032 While rst_n is low, pipe_ready and mdu_ready SHALL be 0 and no transfer or issue SHALL be recorded.
REQ-033 Reset asserted mid-operation SHALL discard all pending bits and any wait count; the first transfer is possible in the first cycle with rst_n high.

Verification
REQ-034 The bench SHALL drive pipe_valid=1, pipe_wa=5, pipe_wd=0x1234 with MDU idle -> pipe_ready=1 that cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0x1234.
REQ-035 The bench SHALL hold pipe_valid=1 and mdu_valid=1 (mdu_wa=7, no pending conflict) continuously with MAX_WAIT=4 -> pipe wins 4 cycles, MDU wins the 5th (wait_cnt 4), and the pattern repeats.
REQ-036 The bench SHALL pulse mdu_issue with wa=9, then request pipe write to 9 -> pipe_ready=0 until MDU writes 9 (pend_mask[9] 1->0); pipe is accepted the following cycle.
REQ-037 The bench SHALL pulse mdu_issue wa=3 in the same cycle an MDU write to 3 is accepted -> pend_mask[3]=1 afterwards; an issue to wa=0 -> pend_mask stays 0.
REQ-038 The bench SHALL drive a pipe write to wa=0 -> pipe_ready=1 and rf_we=0 next cycle.
REQ-039 The bench SHALL assert rst_n=0 for one cycle with pend_mask=0x00000600 and wait_cnt=3 -> all outputs 0 at the edge and both readies 0 during reset.
